ppg_ratio_calc: RTL and testbench
=================================

# ppg_ratio_calc

Windowed ratio-of-ratios engine that sits directly downstream of the LED/PGA controller. It consumes the per-channel RED and IR ADC samples that the controller produces once settings are found. Over each window of samples it tracks min/max per channel and derives AC (peak-to-peak) and DC (midpoint). It then computes R = (AC_red·DC_ir)/(AC_ir·DC_red) in Q2.6 with a sequential divider and presents the result with a one-cycle valid strobe for the SpO2 lookup stage.

## Interface
- WIN_LEN, 256: samples per window (≥2); window counter width $clog2(WIN_LEN)
- CLK  in  1  system clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  high once controller reports settings found; low forces IDLE
- sample_valid  in  1  one-cycle strobe: red_sample/ir_sample hold a new pair
- red_sample  in  8  RED channel ADC value
- ir_sample  in  8  IR channel ADC value
- ratio  out  8  R in unsigned Q2.6 (64 = 1.0), saturated at 255
- ac_red, ac_ir  out  8 each  max−min of last completed window
- dc_red, dc_ir  out  8 each  (max+min)>>1 of last completed window, 9-bit sum before shift
- result_valid  out  1  one-cycle pulse when all result outputs update
- div_zero  out  1  valid with result: denominator was 0
- clip  out  1  valid with result: window contained a 0 or 255 sample (macro only)
- overrun  out  1  one-cycle pulse: window completed while divider busy
- busy  out  1  high in MULT and DIVIDE

## Operation
- States: IDLE, ACCUM, MULT, DIVIDE, DONE.
- IDLE: min regs = 255, max regs = 0, count = 0; go to ACCUM when enable = 1.
- Accumulation runs on every accepted sample_valid in ACCUM, MULT, DIVIDE, DONE (concurrent with computation).
- Per sample: min/max update per channel, count++. On the sample where count reaches WIN_LEN−1: snapshot final min/max (including this sample), reset min/max/count for next window.
- Snapshot when FSM in ACCUM: compute AC/DC into snapshot regs and go to MULT. Snapshot when busy or in DONE: discard it, pulse overrun. Outputs keep the prior result.
- MULT (1 cycle): num = ac_red·dc_ir, den = ac_ir·dc_red, 16 bits each, registered.
- DIVIDE (22 cycles): restoring divide of {num,6'b0} (22 bits) by den, one quotient bit per cycle, MSB first.
- DONE (1 cycle): load outputs; quotient >255 → ratio = 255. den = 0 → ratio = 255, div_zero = 1. Pulse result_valid, then return to ACCUM.
- enable falling in any state: next cycle IDLE, accumulators cleared, divide aborted, no result_valid; result outputs retain last values.
- Reset values: every output 0; FSM IDLE; min 255, max 0, count 0.

## Timing
- Final sample captured on edge T. MULT occupies T+1, DIVIDE T+2..T+23, DONE T+24. result_valid high cycle T+24, outputs updated the same edge.
- overrun pulses the cycle after the discarding snapshot edge.
- sample_valid and enable deassert on the same edge: sample ignored.
- busy deasserts on DONE; a snapshot in DONE counts as overrun.

## Configuration
- PPG_CLIP_DETECT_EN defined: per-window sticky flag set by any red or ir sample equal to 0 or 255. On DONE, clip = flag. If flag is set, ratio is forced to 0 and div_zero is still reported.
- Undefined: clip tied 0, no flag logic, ratio never forced.

## Test plan
- WIN_LEN=4, red 100/140 alternating, ir 110/130 alternating, sample_valid every 30 cycles -> ac_red 40, dc_red 120, ac_ir 20, dc_ir 120, ratio 128, div_zero 0, result_valid exactly 24 cycles after 4th sample.
- WIN_LEN=4, ir constant 128, red 100/140 -> ac_ir 0, ratio 255, div_zero 1.
- WIN_LEN=4, red 60/140, ir 120/124 (num 80·122=9760, den 4·100=400) -> quotient 1561 saturates, ratio 255, div_zero 0.
- WIN_LEN=4, sample_valid every cycle -> first result valid at T+24; windows completing during cycles T+1..T+24 each give an overrun pulse, no extra result_valid.
- enable dropped at T+10 mid-divide -> no result_valid, busy 0 by T+11, outputs hold prior values; re-enable restarts counting from 0.
- With PPG_CLIP_DETECT_EN, red includes 255 in window -> clip 1, ratio 0. Without macro, same stimulus -> clip 0, normal ratio.

Source files
------------

// File: rtl/ppg_ratio_calc_if.sv
// Sample/result bus between the LED/PGA controller, ppg_ratio_calc and the SpO2 lookup stage.
interface ppg_ratio_calc_if;
    logic       enable;
    logic       sample_valid;
    logic [7:0] red_sample;
    logic [7:0] ir_sample;
    logic [7:0] ratio;
    logic [7:0] ac_red;
    logic [7:0] ac_ir;
    logic [7:0] dc_red;
    logic [7:0] dc_ir;
    logic       result_valid;
    logic       div_zero;
    logic       clip;
    logic       overrun;
    logic       busy;

    modport master (
        output enable, sample_valid, red_sample, ir_sample,
        input  ratio, ac_red, ac_ir, dc_red, dc_ir, result_valid, div_zero, clip, overrun, busy
    );

    modport slave (
        input  enable, sample_valid, red_sample, ir_sample,
        output ratio, ac_red, ac_ir, dc_red, dc_ir, result_valid, div_zero, clip, overrun, busy
    );
endinterface

// File: rtl/ppg_ratio_calc.sv
// Windowed min/max tracker and Q2.6 ratio-of-ratios engine with a 22-cycle restoring divider.
// Optional macro PPG_CLIP_DETECT_EN enables per-window clip detection (0/255 samples force ratio 0).
module ppg_ratio_calc #(
    parameter int unsigned WIN_LEN = 256
) (
    input  logic            CLK,
    input  logic            rst_n,
    ppg_ratio_calc_if.slave bus
);
    localparam int unsigned CW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_MULT, S_DIVIDE, S_DONE} state_t;

    state_t        r_state;
    logic [7:0]    r_min_red, r_max_red, r_min_ir, r_max_ir;
    logic [CW-1:0] r_count;
    logic [7:0]    r_ac_red_s, r_dc_red_s, r_ac_ir_s, r_dc_ir_s;
    logic [15:0]   r_den;
    logic [21:0]   r_dvd, r_quo;
    logic [15:0]   r_rem;
    logic [4:0]    r_bit;
    logic [7:0]    r_ratio, r_ac_red, r_ac_ir, r_dc_red, r_dc_ir;
    logic          r_result_valid, r_div_zero, r_clip, r_overrun, r_busy;

    logic          w_accept, w_last, w_ge;
    logic [7:0]    w_min_red, w_max_red, w_min_ir, w_max_ir;
    logic [8:0]    w_sum_red, w_sum_ir;
    logic [15:0]   w_num, w_den, w_sub;
    logic [16:0]   w_rem_sh;
    logic [7:0]    w_ratio;

    assign w_accept  = bus.enable && bus.sample_valid && (r_state != S_IDLE);
    assign w_last    = w_accept && (r_count == CW'(WIN_LEN - 1));
    assign w_min_red = (bus.red_sample < r_min_red) ? bus.red_sample : r_min_red;
    assign w_max_red = (bus.red_sample > r_max_red) ? bus.red_sample : r_max_red;
    assign w_min_ir  = (bus.ir_sample  < r_min_ir)  ? bus.ir_sample  : r_min_ir;
    assign w_max_ir  = (bus.ir_sample  > r_max_ir)  ? bus.ir_sample  : r_max_ir;
    assign w_sum_red = {1'b0, w_max_red} + {1'b0, w_min_red};
    assign w_sum_ir  = {1'b0, w_max_ir}  + {1'b0, w_min_ir};
    assign w_num     = 16'(r_ac_red_s) * 16'(r_dc_ir_s);
    assign w_den     = 16'(r_ac_ir_s)  * 16'(r_dc_red_s);

    // When the compare succeeds the true difference is below 2^16, so 16 bits suffice.
    assign w_rem_sh  = {r_rem, r_dvd[21]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_den});
    assign w_sub     = w_rem_sh[15:0] - r_den;
    assign w_ratio   = ((r_den == '0) || (|r_quo[21:8])) ? 8'hFF : r_quo[7:0];

`ifdef PPG_CLIP_DETECT_EN
    logic r_clip_flag, r_clip_s, w_clip_hit;
    assign w_clip_hit = (bus.red_sample == '0) || (bus.red_sample == '1) ||
                        (bus.ir_sample  == '0) || (bus.ir_sample  == '1);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_clip_flag <= 1'b0;
            r_clip_s    <= 1'b0;
        end else if (!bus.enable) begin
            r_clip_flag <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_clip_flag <= 1'b0;
                if (r_state == S_ACCUM) r_clip_s <= r_clip_flag | w_clip_hit;
            end else begin
                r_clip_flag <= r_clip_flag | w_clip_hit;
            end
        end
    end
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_min_red      <= '1;
            r_max_red      <= '0;
            r_min_ir       <= '1;
            r_max_ir       <= '0;
            r_count        <= '0;
            r_ac_red_s     <= '0;
            r_dc_red_s     <= '0;
            r_ac_ir_s      <= '0;
            r_dc_ir_s      <= '0;
            r_den          <= '0;
            r_dvd          <= '0;
            r_quo          <= '0;
            r_rem          <= '0;
            r_bit          <= '0;
            r_ratio        <= '0;
            r_ac_red       <= '0;
            r_ac_ir        <= '0;
            r_dc_red       <= '0;
            r_dc_ir        <= '0;
            r_result_valid <= 1'b0;
            r_div_zero     <= 1'b0;
            r_clip         <= 1'b0;
            r_overrun      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
            if (!bus.enable) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_min_red <= '1;
                r_max_red <= '0;
                r_min_ir  <= '1;
                r_max_ir  <= '0;
                r_count   <= '0;
            end else begin
                // Window accumulation runs alongside the computation states.
                if (w_accept) begin
                    if (w_last) begin
                        r_min_red <= '1;
                        r_max_red <= '0;
                        r_min_ir  <= '1;
                        r_max_ir  <= '0;
                        r_count   <= '0;
                        if (r_state == S_ACCUM) begin
                            r_ac_red_s <= w_max_red - w_min_red;
                            r_dc_red_s <= 8'(w_sum_red >> 1);
                            r_ac_ir_s  <= w_max_ir - w_min_ir;
                            r_dc_ir_s  <= 8'(w_sum_ir >> 1);
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_min_red <= w_min_red;
                        r_max_red <= w_max_red;
                        r_min_ir  <= w_min_ir;
                        r_max_ir  <= w_max_ir;
                        r_count   <= r_count + CW'(1);
                    end
                end

                case (r_state)
                    S_IDLE: r_state <= S_ACCUM;
                    S_ACCUM: begin
                        if (w_last) begin
                            r_state <= S_MULT;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_MULT: begin
                        r_den   <= w_den;
                        r_dvd   <= {w_num, 6'b0};
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_bit   <= '0;
                        r_state <= S_DIVIDE;
                    end
                    S_DIVIDE: begin
                        r_rem <= w_ge ? w_sub : w_rem_sh[15:0];
                        r_quo <= {r_quo[20:0], w_ge};
                        r_dvd <= {r_dvd[20:0], 1'b0};
                        r_bit <= r_bit + 5'd1;
                        if (r_bit == 5'd21) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        r_ac_red       <= r_ac_red_s;
                        r_dc_red       <= r_dc_red_s;
                        r_ac_ir        <= r_ac_ir_s;
                        r_dc_ir        <= r_dc_ir_s;
                        r_div_zero     <= (r_den == '0);
`ifdef PPG_CLIP_DETECT_EN
                        r_clip         <= r_clip_s;
                        r_ratio        <= r_clip_s ? 8'd0 : w_ratio;
`else
                        r_clip         <= 1'b0;
                        r_ratio        <= w_ratio;
`endif
                        r_result_valid <= 1'b1;
                        r_state        <= S_ACCUM;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ratio        = r_ratio;
    assign bus.ac_red       = r_ac_red;
    assign bus.ac_ir        = r_ac_ir;
    assign bus.dc_red       = r_dc_red;
    assign bus.dc_ir        = r_dc_ir;
    assign bus.result_valid = r_result_valid;
    assign bus.div_zero     = r_div_zero;
    assign bus.clip         = r_clip;
    assign bus.overrun      = r_overrun;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_ppg_ratio_calc.sv
// Directed bench for ppg_ratio_calc with WIN_LEN=4; expected values are hand-computed.
module tb_ppg_ratio_calc;
    logic CLK = 1'b0;
    logic rst_n;

    ppg_ratio_calc_if bus_if ();

    ppg_ratio_calc #(.WIN_LEN(4)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int rv_at, rv_cnt, ov_cnt;
    logic busy1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [7:0] r, input logic [7:0] ir);
        bus_if.sample_valid = 1'b1;
        bus_if.red_sample   = r;
        bus_if.ir_sample    = ir;
        tick();
        bus_if.sample_valid = 1'b0;
    endtask

    // Edge of the 4th sample is T; observation n happens #1 after edge T+n.
    task automatic watch(input int cycles);
        rv_at  = 0;
        rv_cnt = 0;
        ov_cnt = 0;
        for (int n = 1; n <= cycles; n++) begin
            tick();
            if (n == 1) busy1 = bus_if.busy;
            if (bus_if.result_valid) begin
                rv_cnt++;
                if (rv_at == 0) rv_at = n;
            end
            if (bus_if.overrun) ov_cnt++;
        end
    endtask

    task automatic run_window(input logic [7:0] r0, input logic [7:0] i0,
                              input logic [7:0] r1, input logic [7:0] i1);
        pulse(r0, i0); idle(29);
        pulse(r1, i1); idle(29);
        pulse(r0, i0); idle(29);
        pulse(r1, i1);
        watch(40);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus_if.enable       = 1'b0;
        bus_if.sample_valid = 1'b0;
        bus_if.red_sample   = '0;
        bus_if.ir_sample    = '0;
        idle(3);
        check("rst_ratio",   bus_if.ratio, 0);
        check("rst_ac_red",  bus_if.ac_red, 0);
        check("rst_dc_ir",   bus_if.dc_ir, 0);
        check("rst_rv",      bus_if.result_valid, 0);
        check("rst_busy",    bus_if.busy, 0);
        check("rst_overrun", bus_if.overrun, 0);
        check("rst_divzero", bus_if.div_zero, 0);
        check("rst_clip",    bus_if.clip, 0);
        rst_n = 1'b1;
        idle(2);
        bus_if.enable = 1'b1;
        idle(3);

        // Nominal window: 4800*64/2400 = 128
        run_window(8'd100, 8'd110, 8'd140, 8'd130);
        check("t1_busy_T+1", busy1, 1);
        check("t1_rv_at",    rv_at, 24);
        check("t1_rv_cnt",   rv_cnt, 1);
        check("t1_ov_cnt",   ov_cnt, 0);
        check("t1_ac_red",   bus_if.ac_red, 40);
        check("t1_dc_red",   bus_if.dc_red, 120);
        check("t1_ac_ir",    bus_if.ac_ir, 20);
        check("t1_dc_ir",    bus_if.dc_ir, 120);
        check("t1_ratio",    bus_if.ratio, 128);
        check("t1_divzero",  bus_if.div_zero, 0);
        check("t1_busy_end", bus_if.busy, 0);

        // Flat IR channel: denominator 0
        run_window(8'd100, 8'd128, 8'd140, 8'd128);
        check("t2_rv_at",   rv_at, 24);
        check("t2_ac_ir",   bus_if.ac_ir, 0);
        check("t2_dc_ir",   bus_if.dc_ir, 128);
        check("t2_ratio",   bus_if.ratio, 255);
        check("t2_divzero", bus_if.div_zero, 1);

        // 9760*64/400 = 1561 saturates
        run_window(8'd60, 8'd120, 8'd140, 8'd124);
        check("t3_rv_at",   rv_at, 24);
        check("t3_ac_red",  bus_if.ac_red, 80);
        check("t3_dc_red",  bus_if.dc_red, 100);
        check("t3_ac_ir",   bus_if.ac_ir, 4);
        check("t3_dc_ir",   bus_if.dc_ir, 122);
        check("t3_ratio",   bus_if.ratio, 255);
        check("t3_divzero", bus_if.div_zero, 0);

        // Red hits 255: 6600*64/4540 = 93 unless clip detection forces 0
        run_window(8'd255, 8'd110, 8'd200, 8'd130);
        check("t4_rv_at",   rv_at, 24);
        check("t4_ac_red",  bus_if.ac_red, 55);
        check("t4_dc_red",  bus_if.dc_red, 227);
        check("t4_divzero", bus_if.div_zero, 0);
`ifdef PPG_CLIP_DETECT_EN
        check("t4_clip",    bus_if.clip, 1);
        check("t4_ratio",   bus_if.ratio, 0);
`else
        check("t4_clip",    bus_if.clip, 0);
        check("t4_ratio",   bus_if.ratio, 93);
`endif

        // Back-to-back samples: windows at T+4..T+24 are discarded as overruns
        idle(3);
        rv_at  = 0;
        rv_cnt = 0;
        ov_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            bus_if.sample_valid = (k <= 28);
            bus_if.red_sample   = k[0] ? 8'd100 : 8'd140;
            bus_if.ir_sample    = k[0] ? 8'd110 : 8'd130;
            tick();
            if (bus_if.result_valid) begin
                rv_cnt++;
                if (rv_at == 0) rv_at = k;
            end
            if (bus_if.overrun) ov_cnt++;
        end
        bus_if.sample_valid = 1'b0;
        check("t5_rv_at",  rv_at, 28);
        check("t5_rv_cnt", rv_cnt, 1);
        check("t5_ov_cnt", ov_cnt, 6);
        check("t5_ratio",  bus_if.ratio, 128);
        check("t5_clip",   bus_if.clip, 0);

        // Abort mid-divide, with two stray samples counted before the drop
        idle(5);
        pulse(8'd60, 8'd120); idle(3);
        pulse(8'd140, 8'd124); idle(3);
        pulse(8'd60, 8'd120); idle(3);
        pulse(8'd140, 8'd124);
        rv_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            bus_if.sample_valid = (k == 2) || (k == 4);
            bus_if.red_sample   = 8'd10;
            bus_if.ir_sample    = 8'd10;
            tick();
            if (bus_if.result_valid) rv_cnt++;
        end
        bus_if.sample_valid = 1'b0;
        bus_if.enable       = 1'b0;
        tick();
        tick();
        check("t6_busy_T+11", bus_if.busy, 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus_if.result_valid) rv_cnt++;
        end
        check("t6_rv_cnt",  rv_cnt, 0);
        check("t6_ratio",   bus_if.ratio, 128);
        check("t6_ac_red",  bus_if.ac_red, 40);
        check("t6_dc_red",  bus_if.dc_red, 120);
        check("t6_ac_ir",   bus_if.ac_ir, 20);
        check("t6_divzero", bus_if.div_zero, 0);

        // Re-enable: fresh window, 4800*64/2800 = 109
        bus_if.enable = 1'b1;
        idle(2);
        run_window(8'd50, 8'd100, 8'd90, 8'd140);
        check("t7_rv_at",  rv_at, 24);
        check("t7_rv_cnt", rv_cnt, 1);
        check("t7_ac_red", bus_if.ac_red, 40);
        check("t7_dc_red", bus_if.dc_red, 70);
        check("t7_ac_ir",  bus_if.ac_ir, 40);
        check("t7_dc_ir",  bus_if.dc_ir, 120);
        check("t7_ratio",  bus_if.ratio, 109);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
